// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: carries {valid, data} through one or two registered
// stages with an asynchronous active-low clear. Data holds while no result arrives.
module sram_rd_pipe #(
  parameter int WIDTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic             vld_p0_d, vld_p0_q;
  logic [WIDTH-1:0] data_p0_d, data_p0_q;

  always_comb begin
    vld_p0_d  = in_vld;
    data_p0_d = in_vld ? in_data : data_p0_q;
  end

  // stage p0: first registered copy of the read result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q  <= 1'b0;
      data_p0_q <= '0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      data_p0_q <= data_p0_d;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign out_vld  = vld_p0_q;
    assign out_data = data_p0_q;
  end else if (RD_LAT == 2) begin : g_lat2
    logic             vld_p1_d, vld_p1_q;
    logic [WIDTH-1:0] data_p1_d, data_p1_q;

    always_comb begin
      vld_p1_d  = vld_p0_q;
      data_p1_d = vld_p0_q ? data_p0_q : data_p1_q;
    end

    // stage p1: output register for the two-cycle configuration
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p1_q  <= 1'b0;
        data_p1_q <= '0;
      end else begin
        vld_p1_q  <= vld_p1_d;
        data_p1_q <= data_p1_d;
      end
    end

    assign out_vld  = vld_p1_q;
    assign out_data = data_p1_q;
  end else begin : g_bad_lat
    $error("sram_rd_pipe: RD_LAT must be 1 or 2");
  end

endmodule

// File: rtl/sram_wd.sv
// Parametrised single-port synchronous SRAM with per-bit active-low write mask,
// configurable read latency and a read-valid strobe. The array itself is never reset.
module sram_wd #(
  parameter  int sram_bit  = 64,
  parameter  int num_words = 16,
  parameter  int rd_lat    = 1,
  localparam int addr_bit  = $clog2(num_words)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                CEN,
  input  logic                WEN,
  input  logic [addr_bit-1:0] A,
  input  logic [sram_bit-1:0] D,
  input  logic [sram_bit-1:0] BWEN,
  output logic [sram_bit-1:0] Q,
  output logic                QV
);

  localparam logic [addr_bit:0] DEPTH = (addr_bit + 1)'(num_words);

  logic [sram_bit-1:0] mem_q [num_words];

  logic                in_range;
  logic                wr_en;
  logic                rd_en;
  logic [sram_bit-1:0] wr_word_d;
  logic [sram_bit-1:0] rd_word;

  always_comb begin
    in_range  = ({1'b0, A} < DEPTH);
    wr_en     = !CEN && !WEN && in_range;
    rd_en     = !CEN && WEN;
    rd_word   = '0;
    wr_word_d = '0;
    // out-of-range addresses read as zero but still return a valid strobe
    if (in_range) begin
      rd_word   = mem_q[A];
      wr_word_d = (mem_q[A] & BWEN) | (D & ~BWEN);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[A] <= wr_word_d;
    end
  end

  sram_rd_pipe #(
    .WIDTH  (sram_bit),
    .RD_LAT (rd_lat)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (rd_en),
    .in_data  (rd_word),
    .out_vld  (QV),
    .out_data (Q)
  );

  a_cen_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(CEN));

endmodule

// File: tb/tb_sram_wd.sv
// Scoreboard bench: two instances (16 words / latency 1, 12 words / latency 2)
// share one randomized stimulus stream and are checked against a word-level model.
module tb_sram_wd;
  localparam int W = 64;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] known;
    int           due;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         CEN   = 1'b1;
  logic         WEN   = 1'b1;
  logic [3:0]   A     = '0;
  logic [W-1:0] D     = '0;
  logic [W-1:0] BWEN  = '1;
  logic [W-1:0] q0, q1;
  logic         qv0, qv1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int           depth  [2] = '{16, 12};
  int           lat    [2] = '{1, 2};
  logic [W-1:0] mval   [2][16];
  logic [W-1:0] mknown [2][16];
  exp_t         sb0[$];
  exp_t         sb1[$];
  exp_t         last   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_wd #(.sram_bit(W), .num_words(16), .rd_lat(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .BWEN(BWEN),
    .Q(q0), .QV(qv0));

  sram_wd #(.sram_bit(W), .num_words(12), .rd_lat(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .BWEN(BWEN),
    .Q(q1), .QV(qv1));

  function automatic void check(string name, int k, logic [W-1:0] act,
                                logic [W-1:0] exp, logic [W-1:0] known);
    n_cmp++;
    if (((act ^ exp) & known) !== '0) begin
      n_err++;
      $display("FAIL %s dut%0d @cyc %0d: got %h expected %h (mask %h)",
               name, k, cyc, act, exp, known);
    end
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t qpop(int k);
    return (k == 0) ? sb0.pop_front() : sb1.pop_front();
  endfunction

  function automatic void qpush(int k, exp_t e);
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endfunction

  // reference model: word-level array with a per-bit "has been written" mask
  task automatic op(input bit cen, input bit wen, input logic [3:0] a,
                    input logic [W-1:0] d, input logic [W-1:0] bwen);
    exp_t e;
    @(negedge clk);
    #1;
    CEN = cen; WEN = wen; A = a; D = d; BWEN = bwen;
    if (rst_n && !cen) begin
      for (int k = 0; k < 2; k++) begin
        if (!wen) begin
          if (int'(a) < depth[k]) begin
            mval[k][a]   = (mval[k][a] & bwen) | (d & ~bwen);
            mknown[k][a] = mknown[k][a] | ~bwen;
          end
        end else begin
          if (int'(a) < depth[k]) begin
            e.data  = mval[k][a];
            e.known = mknown[k][a];
          end else begin
            e.data  = '0;
            e.known = '1;
          end
          e.due = cyc + lat[k];
          qpush(k, e);
        end
      end
    end
  endtask

  task automatic mon(input int k, input logic [W-1:0] q, input logic qv);
    exp_t e;
    if (qv) begin
      if (qsize(k) == 0) begin
        check("spurious_qv", k, 64'd1, 64'd0, '1);
      end else begin
        e = qpop(k);
        check("rd_latency", k, 64'(cyc), 64'(e.due), '1);
        check("rd_data", k, q, e.data, e.known);
        last[k] = e;
      end
    end else begin
      if (qsize(k) != 0) begin
        if ((k == 0 ? sb0[0].due : sb1[0].due) <= cyc) begin
          e = qpop(k);
          check("missing_qv", k, 64'd0, 64'd1, '1);
        end
      end
      check("q_hold", k, q, last[k].data, last[k].known);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_q", 0, q0, '0, '1);
      check("rst_qv", 0, {63'd0, qv0}, '0, '1);
      check("rst_q", 1, q1, '0, '1);
      check("rst_qv", 1, {63'd0, qv1}, '0, '1);
      for (int k = 0; k < 2; k++) begin
        last[k].data  = '0;
        last[k].known = '1;
      end
    end else begin
      mon(0, q0, qv0);
      mon(1, q1, qv1);
    end
  end

  initial begin
    logic [W-1:0] bw;
    for (int k = 0; k < 2; k++) begin
      last[k].data  = '0;
      last[k].known = '1;
      for (int i = 0; i < 16; i++) begin
        mval[k][i]   = '0;
        mknown[k][i] = '0;
      end
    end

    // reset held while reads are requested
    for (int i = 0; i < 6; i++) op(1'($urandom_range(0, 1)), 1'b1, 4'($urandom), '0, '1);
    @(negedge clk); #1; rst_n = 1'b1;

    // first read of an unwritten word: only the strobe timing is defined
    op(1'b0, 1'b1, 4'd7, '0, '1);
    op(1'b1, 1'b1, 4'd0, '0, '1);

    // full sweep: writes then back-to-back reads
    for (int i = 0; i < 16; i++) op(1'b0, 1'b0, 4'(i), 64'h1111_1111_1111_1111 * 64'(i), '0);
    for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 4'(i), '0, '1);
    op(1'b1, 1'b1, 4'd0, '0, '1);

    // bit mask on addr 3
    op(1'b0, 1'b0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, '0);
    op(1'b0, 1'b0, 4'd3, 64'h0, 64'hFFFF_FFFF_0000_0000);
    op(1'b0, 1'b1, 4'd3, '0, '1);
    op(1'b1, 1'b1, 4'd0, '0, '1);

    // gapped reads, then hold
    op(1'b0, 1'b1, 4'd5, '0, '1);
    op(1'b1, 1'b1, 4'd0, '0, '1);
    op(1'b0, 1'b1, 4'd6, '0, '1);
    for (int i = 0; i < 4; i++) op(1'b1, 1'b1, 4'd0, '0, '1);

    // out-of-range write/read on the 12-word instance
    op(1'b0, 1'b0, 4'd13, 64'hDEAD_BEEF_CAFE_F00D, '0);
    op(1'b0, 1'b1, 4'd13, '0, '1);
    for (int i = 0; i < 12; i++) op(1'b0, 1'b1, 4'(i), '0, '1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       bw = '0;
        1:       bw = '1;
        default: bw = {$urandom, $urandom};
      endcase
      op(($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), {$urandom, $urandom}, bw);
    end

    // reset with a read in flight
    op(1'b0, 1'b0, 4'd9, 64'h0123_4567_89AB_CDEF, '0);
    op(1'b0, 1'b1, 4'd9, '0, '1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    CEN   = 1'b1;
    sb0.delete();
    sb1.delete();
    #1;
    check("midrst_q", 0, q0, '0, '1);
    check("midrst_qv", 0, {63'd0, qv0}, '0, '1);
    check("midrst_q", 1, q1, '0, '1);
    check("midrst_qv", 1, {63'd0, qv1}, '0, '1);
    @(negedge clk); @(negedge clk); #1; rst_n = 1'b1;
    op(1'b0, 1'b1, 4'd9, '0, '1);
    op(1'b0, 1'b1, 4'd3, '0, '1);

    for (int i = 0; i < 5; i++) op(1'b1, 1'b1, 4'd0, '0, '1);
    @(negedge clk); #1;
    check("drain", 0, 64'(sb0.size()), 64'd0, '1);
    check("drain", 1, 64'(sb1.size()), 64'd0, '1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
